// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment counter:
// active-low glyph table, blank pattern, digit limits and counter action encoding.
package seven_seg_pkg;

   // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
   localparam logic [0:15][6:0] GLYPH_TABLE = {
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_CLEAR,
      ACT_LOAD,
      ACT_INC,
      ACT_DEC
   } count_act_e;

   function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
      return GLYPH_TABLE[digit];
   endfunction

   function automatic logic [3:0] digit_max(input logic decimal);
      return decimal ? 4'd9 : 4'hF;
   endfunction

endpackage

// File: rtl/seven_segment_counter_mux_button_conditioner.sv
// Pushbutton front end: synchroniser, debounce filter and step-pulse generator
// with optional hold-to-repeat.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000,
   parameter bit REPEAT_EN           = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic pulse
);

   localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int REP_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                            REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_CYCLES - 1);

   logic             sync_a;
   logic             sync_b;
   logic [DB_W-1:0]  db_cnt;
   logic             level_d;
   logic [REP_W-1:0] rep_cnt;
   logic             repeating;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level  <= 1'b0;
         db_cnt <= '0;
      end else if (sync_b == level) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         level  <= sync_b;
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_d   <= 1'b0;
         pulse     <= 1'b0;
         rep_cnt   <= '0;
         repeating <= 1'b0;
      end else begin
         level_d <= level;
         pulse   <= 1'b0;
         if (level && !level_d) begin
            pulse     <= 1'b1;
            rep_cnt   <= '0;
            repeating <= 1'b0;
         end else if (REPEAT_EN && level) begin
            if (!repeating && rep_cnt == DELAY_LAST) begin
               pulse     <= 1'b1;
               rep_cnt   <= '0;
               repeating <= 1'b1;
            end else if (repeating && rep_cnt == RATE_LAST) begin
               pulse   <= 1'b1;
               rep_cnt <= '0;
            end else begin
               rep_cnt <= rep_cnt + 1'b1;
            end
         end else begin
            rep_cnt   <= '0;
            repeating <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit hex/BCD up/down counter driven by debounced pushbuttons, with a
// time-multiplexed, optionally leading-zero-blanked seven-segment display.
module seven_segment_counter_mux
   import seven_seg_pkg::*;
#(
   parameter int DIGITS              = 4,
   parameter int DEBOUNCE_CYCLES     = 1_000_000,
   parameter int REPEAT_DELAY_CYCLES = 50_000_000,
   parameter int REPEAT_RATE_CYCLES  = 10_000_000,
   parameter int SCAN_CYCLES         = 100_000,
   parameter bit BLANK_LZ            = 1'b0
) (
   input  logic                  CLK100MHZ,
   input  logic                  CPU_RESETN,
   input  logic                  BTNU,
   input  logic                  BTND,
   input  logic                  BTNR,
   input  logic                  BTNL,
   input  logic [4*DIGITS-1:0]   SW,
   input  logic                  MODE,
   output logic                  CA,
   output logic                  CB,
   output logic                  CC,
   output logic                  CD,
   output logic                  CE,
   output logic                  CF,
   output logic                  CG,
   output logic [7:0]            AN,
   output logic [4*DIGITS-1:0]   COUNT,
   output logic                  WRAP
);

   localparam int PRE_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [1:0]          rst_pipe;
   logic                rst_n;
   logic                mode_a, mode_b, mode_d;
   logic                mode_change;
   logic                u_pulse, d_pulse, r_pulse, l_pulse;
   count_act_e          act;
   logic [3:0]          max_digit;
   logic [4*DIGITS-1:0] count;
   logic [4*DIGITS-1:0] inc_val, dec_val, load_val;
   logic                inc_carry, dec_borrow;
   logic                wrap;
   logic [PRE_W-1:0]    pre_cnt_p0;
   logic [IDX_W-1:0]    scan_idx_p0;
   logic [DIGITS-1:0]   lit;
   logic                seen;
   logic [3:0]          sel_digit;
   logic                sel_lit;
   logic [7:0]          an_next;
   logic [7:0]          an_p1;
   logic [6:0]          seg_p1;

   // Assert asynchronously, release two clocks after CPU_RESETN rises.
   always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
      if (!CPU_RESETN) rst_pipe <= 2'b00;
      else             rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_n = rst_pipe[1];

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b1)
   ) u_btn_up (.clk(CLK100MHZ), .rst_n(rst_n), .raw(BTNU), .level(), .pulse(u_pulse));

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b1)
   ) u_btn_down (.clk(CLK100MHZ), .rst_n(rst_n), .raw(BTND), .level(), .pulse(d_pulse));

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b0)
   ) u_btn_clear (.clk(CLK100MHZ), .rst_n(rst_n), .raw(BTNR), .level(), .pulse(r_pulse));

   button_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES(REPEAT_RATE_CYCLES), .REPEAT_EN(1'b0)
   ) u_btn_load (.clk(CLK100MHZ), .rst_n(rst_n), .raw(BTNL), .level(), .pulse(l_pulse));

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         mode_a <= 1'b0;
         mode_b <= 1'b0;
         mode_d <= 1'b0;
      end else begin
         mode_a <= MODE;
         mode_b <= mode_a;
         mode_d <= mode_b;
      end
   end
   assign mode_change = mode_b ^ mode_d;
   assign max_digit   = digit_max(mode_b);

   // A radix change invalidates the current value, so it outranks every button.
   always_comb begin
      act = ACT_NONE;
      if (mode_change)            act = ACT_CLEAR;
      else if (r_pulse)           act = ACT_CLEAR;
      else if (l_pulse)           act = ACT_LOAD;
      else if (u_pulse && !d_pulse) act = ACT_INC;
      else if (d_pulse && !u_pulse) act = ACT_DEC;
   end

   always_comb begin
      inc_val    = count;
      dec_val    = count;
      load_val   = '0;
      inc_carry  = 1'b1;
      dec_borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (inc_carry) begin
            if (count[4*i +: 4] >= max_digit) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
               inc_carry = 1'b0;
            end
         end
         if (dec_borrow) begin
            if (count[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = max_digit;
            end else begin
               dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
               dec_borrow = 1'b0;
            end
         end
         load_val[4*i +: 4] = (SW[4*i +: 4] > max_digit) ? max_digit : SW[4*i +: 4];
      end
   end

   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         wrap  <= 1'b0;
      end else begin
         wrap <= 1'b0;
         case (act)
            ACT_CLEAR: count <= '0;
            ACT_LOAD:  count <= load_val;
            ACT_INC: begin
               count <= inc_val;
               wrap  <= inc_carry;
            end
            ACT_DEC: begin
               count <= dec_val;
               wrap  <= dec_borrow;
            end
            default: ;
         endcase
      end
   end

   // Stage p0: prescaler and scan index.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt_p0  <= '0;
         scan_idx_p0 <= '0;
      end else if (pre_cnt_p0 == PRE_LAST) begin
         pre_cnt_p0  <= '0;
         scan_idx_p0 <= (scan_idx_p0 == IDX_LAST) ? '0 : scan_idx_p0 + 1'b1;
      end else begin
         pre_cnt_p0 <= pre_cnt_p0 + 1'b1;
      end
   end

   always_comb begin
      seen = 1'b0;
      lit  = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (count[4*i +: 4] != 4'd0) seen = 1'b1;
         lit[i] = seen || (i == 0) || !BLANK_LZ;
      end
      sel_digit = 4'd0;
      sel_lit   = 1'b0;
      an_next   = 8'hFF;
      for (int i = 0; i < DIGITS; i++) begin
         if (scan_idx_p0 == IDX_W'(i)) begin
            sel_digit  = count[4*i +: 4];
            sel_lit    = lit[i];
            an_next[i] = 1'b0;
         end
      end
   end

   // Stage p1: anode and cathode registers load together so digits never ghost.
   always_ff @(posedge CLK100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         an_p1  <= 8'hFE;
         seg_p1 <= digit_to_seg(4'd0);
      end else begin
         an_p1  <= an_next;
         seg_p1 <= sel_lit ? digit_to_seg(sel_digit) : SEG_BLANK;
      end
   end

   assign {CA, CB, CC, CD, CE, CF, CG} = seg_p1;
   assign AN    = an_p1;
   assign COUNT = count;
   assign WRAP  = wrap;

endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed bench for seven_segment_counter_mux with a COUNT scoreboard queue.
module tb_seven_segment_counter_mux;

   localparam int DIGITS = 4;

   logic                clk = 1'b0;
   logic                CPU_RESETN;
   logic                BTNU, BTND, BTNR, BTNL, MODE;
   logic [4*DIGITS-1:0] SW;
   logic                CA, CB, CC, CD, CE, CF, CG;
   logic [7:0]          AN;
   logic [4*DIGITS-1:0] COUNT;
   logic                WRAP;
   logic [6:0]          seg;

   typedef struct {
      string       tag;
      logic [15:0] value;
   } exp_t;

   exp_t exp_q[$];
   int   n_asserts = 0;
   int   n_fail    = 0;
   int   wrap_seen = 0;

   always #5 clk = ~clk;

   assign seg = {CA, CB, CC, CD, CE, CF, CG};

   seven_segment_counter_mux #(
      .DIGITS(DIGITS), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(40),
      .REPEAT_RATE_CYCLES(10), .SCAN_CYCLES(8), .BLANK_LZ(1'b1)
   ) dut (
      .CLK100MHZ(clk), .CPU_RESETN(CPU_RESETN),
      .BTNU(BTNU), .BTND(BTND), .BTNR(BTNR), .BTNL(BTNL),
      .SW(SW), .MODE(MODE),
      .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
      .AN(AN), .COUNT(COUNT), .WRAP(WRAP)
   );

   always @(negedge clk) if (WRAP === 1'b1) wrap_seen++;

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push_count(input string tag, input logic [15:0] v);
      exp_q.push_back('{tag: tag, value: v});
   endtask

   task automatic pop_check_count();
      exp_t e;
      if (exp_q.size() == 0) begin
         n_asserts++;
         n_fail++;
         $display("FAIL scoreboard_empty: observed COUNT %h with no expected entry", COUNT);
      end else begin
         e = exp_q.pop_front();
         check(e.tag, {16'h0, COUNT}, {16'h0, e.value});
      end
   endtask

   task automatic press(input logic u, input logic d, input logic r, input logic l);
      BTNU = u; BTND = d; BTNR = r; BTNL = l;
      cycles(12);
      BTNU = 1'b0; BTND = 1'b0; BTNR = 1'b0; BTNL = 1'b0;
      cycles(12);
   endtask

   task automatic load(input string tag, input logic [15:0] sw_val, input logic [15:0] exp);
      SW = sw_val;
      push_count(tag, exp);
      press(1'b0, 1'b0, 1'b0, 1'b1);
      pop_check_count();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] an_exp  [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
      logic [6:0] seg_exp [4] = '{7'b0010010, 7'b1001100, 7'b1111111, 7'b1111111};
      int         an_match[4];
      logic [6:0] seg_got [4];
      int         upper_bad;
      int         wrap0;
      logic [7:0] an_prev;
      logic       found;

      CPU_RESETN = 1'b0;
      BTNU = 1'b0; BTND = 1'b0; BTNR = 1'b0; BTNL = 1'b0;
      MODE = 1'b0;
      SW   = '0;
      cycles(3);
      check("reset_count", {16'h0, COUNT}, 32'h0);
      check("reset_an",    {24'h0, AN},    32'hFE);
      check("reset_seg",   {25'h0, seg},   32'h01);
      check("reset_wrap",  {31'h0, WRAP},  32'h0);
      CPU_RESETN = 1'b1;
      cycles(4);

      // Asynchronous reset in the middle of a scan with a non-zero count.
      load("load_12ab", 16'h12AB, 16'h12AB);
      cycles(13);
      #3 CPU_RESETN = 1'b0;
      #1;
      check("async_reset_count", {16'h0, COUNT}, 32'h0);
      check("async_reset_an",    {24'h0, AN},    32'hFE);
      check("async_reset_seg",   {25'h0, seg},   32'h01);
      @(negedge clk);
      CPU_RESETN = 1'b1;
      cycles(4);

      // Hex increment with carry, then a bouncing button that must not step.
      load("load_00ff", 16'h00FF, 16'h00FF);
      push_count("inc_00ff", 16'h0100);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      pop_check_count();

      push_count("bounce_no_step", 16'h0100);
      repeat (6) begin
         BTNU = 1'b1; cycles(3);
         BTNU = 1'b0; cycles(2);
      end
      cycles(12);
      pop_check_count();

      // Hold-to-repeat from zero.
      push_count("clear", 16'h0000);
      press(1'b0, 1'b0, 1'b1, 1'b0);
      pop_check_count();
      BTNU = 1'b1;
      for (int k = 0; k < 40 && COUNT == 16'h0; k++) @(negedge clk);
      check("hold_first_step", {16'h0, COUNT}, 32'h1);
      cycles(66);
      BTNU = 1'b0;
      push_count("hold_75", 16'h0005);
      cycles(30);
      pop_check_count();
      push_count("hold_release_stops", 16'h0005);
      cycles(50);
      pop_check_count();

      // Decimal mode: mode change clears, load clamps, wrap both ways.
      MODE = 1'b1;
      push_count("mode_to_dec_clear", 16'h0000);
      cycles(10);
      pop_check_count();
      load("load_99f9_dec", 16'h99F9, 16'h9999);
      wrap0 = wrap_seen;
      push_count("dec_inc_wrap", 16'h0000);
      press(1'b1, 1'b0, 1'b0, 1'b0);
      pop_check_count();
      check("wrap_pulse_up", wrap_seen - wrap0, 1);
      wrap0 = wrap_seen;
      push_count("dec_dec_wrap", 16'h9999);
      press(1'b0, 1'b1, 1'b0, 1'b0);
      pop_check_count();
      check("wrap_pulse_down", wrap_seen - wrap0, 1);

      // Button conflicts.
      push_count("up_down_conflict", 16'h9999);
      press(1'b1, 1'b1, 1'b0, 1'b0);
      pop_check_count();
      SW = 16'h1234;
      push_count("clear_beats_load", 16'h0000);
      press(1'b0, 1'b0, 1'b1, 1'b1);
      pop_check_count();

      // Mode toggle clears a non-zero value.
      load("load_0042", 16'h0042, 16'h0042);
      MODE = 1'b0;
      push_count("mode_toggle_clear", 16'h0000);
      cycles(10);
      pop_check_count();

      // Display scan with leading-zero blanking.
      load("load_0042_scan", 16'h0042, 16'h0042);
      an_prev = AN;
      found   = 1'b0;
      for (int k = 0; k < 80 && !found; k++) begin
         @(negedge clk);
         if (AN == 8'hFE && an_prev != 8'hFE) found = 1'b1;
         else an_prev = AN;
      end
      check("scan_align", {31'h0, found}, 32'h1);
      for (int d = 0; d < 4; d++) begin
         an_match[d] = 0;
         seg_got[d]  = 7'h00;
      end
      upper_bad = 0;
      for (int c = 0; c < 32; c++) begin
         if (c > 0) @(negedge clk);
         if (AN === an_exp[c/8]) an_match[c/8]++;
         if (c % 8 == 3) seg_got[c/8] = seg;
         if (AN[7:4] !== 4'hF) upper_bad++;
      end
      for (int d = 0; d < 4; d++) begin
         check($sformatf("scan_an_dwell_%0d", d), an_match[d], 8);
         check($sformatf("scan_seg_%0d", d), {25'h0, seg_got[d]}, {25'h0, seg_exp[d]});
      end
      check("scan_an_upper_off", upper_bad, 0);
      @(negedge clk);
      check("scan_wraps_to_digit0", {24'h0, AN}, 32'hFE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
